// File: rtl/sobel_result_sink.sv
// -----------------------------------------------------------------------------
// sobel_result_sink
//   Receiving end of the sobel_edge result-write interface. Each result beat
//   (in_valid/in_addr/in_pixel) is captured into a small FIFO and replayed to
//   frame memory over a valid/ready write port, so a stalling memory never
//   back-pressures the fixed-rate engine. Frame completion, dropped beats and
//   out-of-range addresses are reported to the frame controller.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start          level; its rising edge arms capture of one frame (IDLE only)
//   in_valid       result beat valid
//   in_addr        result pixel address
//   in_pixel       result pixel value
//   mem_wr_valid   head of FIFO is presented to frame memory
//   mem_wr_ready   frame memory accepts the presented beat
//   mem_wr_addr    write address (head entry, 0 when FIFO empty)
//   mem_wr_data    write data    (head entry, 0 when FIFO empty)
//   busy           high while capturing or draining
//   frame_done     one-cycle pulse once the whole frame has been written
//   overflow       sticky: a beat was dropped because the FIFO was full
//   addr_err       sticky: a beat with an out-of-frame address was dropped
//   pix_count      beats accepted into the FIFO this frame
// -----------------------------------------------------------------------------
module sobel_result_sink #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int PIX_W      = 8,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [PIX_W-1:0]  in_pixel,
   output logic              mem_wr_valid,
   input  logic              mem_wr_ready,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [PIX_W-1:0]  mem_wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow,
   output logic              addr_err,
   output logic [ADDR_W-1:0] pix_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = FRAME_PIX - ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state;
   logic              start_q;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW:0]       occ;
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [PIX_W-1:0]  data_mem [FIFO_DEPTH];

   logic start_rise;
   logic empty;
   logic full;
   logic pop;
   logic beat;
   logic in_range;
   logic push;
   logic drop_full;
   logic last_beat;
   logic drain_empty;

   always_comb begin
      start_rise  = start && !start_q;
      empty       = (wr_ptr == rd_ptr);
      full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      occ         = wr_ptr - rd_ptr;
      pop         = !empty && mem_wr_ready;
      beat        = (state == S_CAPTURE) && in_valid;
      in_range    = (in_addr < FRAME_PIX);
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      push        = beat && in_range && (!full || pop);
      drop_full   = beat && in_range && full && !pop;
      last_beat   = push && (in_addr == LAST_ADDR);
      // True when the FIFO is empty after this edge (no pushes in DRAIN).
      drain_empty = empty || (pop && (occ == (AW+1)'(1)));
   end

   // First-word fall-through: the head entry is always on the write port.
   assign mem_wr_valid = !empty;
   assign mem_wr_addr  = empty ? '0 : addr_mem[rd_ptr[AW-1:0]];
   assign mem_wr_data  = empty ? '0 : data_mem[rd_ptr[AW-1:0]];

   // Control FSM with registered busy/frame_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            S_IDLE: begin
               frame_done <= 1'b0;
               if (start_rise) begin
                  state <= S_CAPTURE;
                  busy  <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (last_beat) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (drain_empty) begin
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: begin
               state      <= S_IDLE;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers; AW+1 bits so they wrap modulo 2*FIFO_DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // FIFO storage; contents are only visible behind the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr[AW-1:0]] <= in_addr;
         data_mem[wr_ptr[AW-1:0]] <= in_pixel;
      end
   end

   // Frame status; cleared on entry to CAPTURE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_count <= '0;
         overflow  <= 1'b0;
         addr_err  <= 1'b0;
      end else if ((state == S_IDLE) && start_rise) begin
         pix_count <= '0;
         overflow  <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         if (push)                 pix_count <= pix_count + ADDR_W'(1);
         if (drop_full)            overflow  <= 1'b1;
         if (beat && !in_range)    addr_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sobel_result_sink.sv
module tb_sobel_result_sink;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 4;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int FRAME  = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [ADDR_W-1:0] in_addr = '0;
   logic [PIX_W-1:0]  in_pixel = '0;
   logic              mem_wr_valid;
   logic              mem_wr_ready = 1'b0;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [PIX_W-1:0]  mem_wr_data;
   logic              busy;
   logic              frame_done;
   logic              overflow;
   logic              addr_err;
   logic [ADDR_W-1:0] pix_count;

   sobel_result_sink #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_addr(in_addr), .in_pixel(in_pixel),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .busy(busy), .frame_done(frame_done), .overflow(overflow),
      .addr_err(addr_err), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [PIX_W-1:0]  d;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    m_cap  = 0;
   bit    m_ovf  = 0;
   bit    m_aerr = 0;
   int    m_cnt  = 0;
   int    fd_count = 0;
   bit    prev_stall = 0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [PIX_W-1:0]  prev_data = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard: sample on the falling edge, predict what the next rising edge does.
   always @(negedge clk) begin
      int  sz;
      bit  pop;
      if (rst) begin
         prev_stall = 0;
      end else begin
         check("wr_valid", mem_wr_valid, q.size() != 0);
         check("pix_count", pix_count, m_cnt);
         check("overflow", overflow, m_ovf);
         check("addr_err", addr_err, m_aerr);
         if (frame_done) fd_count++;
         if (prev_stall && mem_wr_valid) begin
            check("stall_addr", mem_wr_addr, prev_addr);
            check("stall_data", mem_wr_data, prev_data);
         end
         if (mem_wr_valid && q.size() != 0) begin
            check("wr_addr", mem_wr_addr, q[0].a);
            check("wr_data", mem_wr_data, q[0].d);
         end
         pop        = mem_wr_valid && mem_wr_ready;
         prev_stall = mem_wr_valid && !mem_wr_ready;
         prev_addr  = mem_wr_addr;
         prev_data  = mem_wr_data;
         sz = q.size();
         if (pop && sz != 0) void'(q.pop_front());
         if (m_cap && in_valid) begin
            if (in_addr >= ADDR_W'(FRAME)) m_aerr = 1;
            else if (sz == DEPTH && !pop) m_ovf = 1;
            else begin
               q.push_back({in_addr, in_pixel});
               m_cnt++;
               if (in_addr == ADDR_W'(FRAME - 1)) m_cap = 0;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      start = 1'b0;
      q.delete();
      m_cap = 0; m_cnt = 0; m_ovf = 0; m_aerr = 0;
      #1;
      check("rst_wr_valid", mem_wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_cap = 1; m_cnt = 0; m_ovf = 0; m_aerr = 0;
      check("busy_start", busy, 1);
   endtask

   task automatic beat(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] p);
      in_valid = 1'b1;
      in_addr  = a;
      in_pixel = p;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int f0 = fd_count;
      int i  = 0;
      while (fd_count == f0 && i < 400) begin
         @(posedge clk);
         i++;
      end
      #1;
      check({tag, "_done_seen"}, fd_count - f0, 1);
      check({tag, "_q_empty"}, q.size(), 0);
      check({tag, "_busy_idle"}, busy, 0);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_one_pulse"}, fd_count - f0, 1);
   endtask

   initial begin
      int fd_before;
      // 1: reset, then beats while idle are ignored
      @(posedge clk); #1;
      do_reset();
      check("idle_busy", busy, 0);
      check("idle_overflow", overflow, 0);
      check("idle_addr_err", addr_err, 0);
      check("idle_pix_count", pix_count, 0);
      check("idle_wr_addr", mem_wr_addr, 0);
      check("idle_wr_data", mem_wr_data, 0);
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) beat(ADDR_W'(i), PIX_W'(i + 1));
      @(posedge clk); #1;
      check("idle_ignored_cnt", pix_count, 0);
      check("idle_ignored_valid", mem_wr_valid, 0);

      // 2: clean full frame, memory always ready
      start_frame();
      for (int i = 0; i < FRAME; i++) beat(ADDR_W'(i), PIX_W'($urandom));
      wait_done("full");
      check("full_pix_count", pix_count, FRAME);
      check("full_overflow", overflow, 0);
      check("full_addr_err", addr_err, 0);

      // 3: 20-cycle memory stall mid-frame
      start_frame();
      for (int i = 0; i < FRAME; i++) begin
         mem_wr_ready = !(i >= 10 && i < 30);
         beat(ADDR_W'(i), PIX_W'($urandom));
      end
      mem_wr_ready = 1'b1;
      wait_done("stall");
      check("stall_overflow", overflow, 1);
      check("stall_dropped", pix_count < ADDR_W'(FRAME), 1);

      // 4: out-of-range addresses with random back-pressure
      start_frame();
      for (int i = 0; i < FRAME; i++) begin
         mem_wr_ready = ($urandom_range(0, 3) != 0);
         if (i == 7)  beat(ADDR_W'(FRAME), 8'hAA);
         if (i == 20) beat(32'hFFFF_FFFF, 8'h55);
         beat(ADDR_W'(i), PIX_W'($urandom));
      end
      mem_wr_ready = 1'b1;
      wait_done("aerr");
      check("aerr_flag", addr_err, 1);

      // 5: full FIFO with simultaneous pop and push
      start_frame();
      mem_wr_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) beat(ADDR_W'(i), PIX_W'(i + 8'h40));
      mem_wr_ready = 1'b1;
      beat(ADDR_W'(DEPTH), 8'h99);
      check("fullpp_overflow", overflow, 0);
      check("fullpp_count", pix_count, DEPTH + 1);
      mem_wr_ready = 1'b0;
      beat(ADDR_W'(DEPTH + 1), 8'h77);
      check("fullpp_still_full", overflow, 1);
      mem_wr_ready = 1'b1;
      for (int i = DEPTH + 2; i < FRAME; i++) beat(ADDR_W'(i), PIX_W'($urandom));
      wait_done("fullpp");

      // 6: reset with entries queued, then a clean frame
      start_frame();
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) beat(ADDR_W'(i), PIX_W'(i));
      check("midrst_queued", mem_wr_valid, 1);
      fd_before = fd_count;
      do_reset();
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_done", fd_count - fd_before, 0);
      check("midrst_valid", mem_wr_valid, 0);
      mem_wr_ready = 1'b1;
      start_frame();
      for (int i = 0; i < FRAME; i++) beat(ADDR_W'(i), PIX_W'($urandom));
      wait_done("clean");
      check("clean_pix_count", pix_count, FRAME);
      check("clean_overflow", overflow, 0);

      check("frame_total", fd_count, 5);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
